// File: rtl/i2c_slave.sv
// Single-address I2C slave clocked by SCL: START/STOP detection, write capture, loopback reads.
// Build option: define I2C_SLAVE_ADDR_MATCH_EN to respond only to SLAVE_ADDR (otherwise promiscuous).
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h28
) (
    input  logic       SCL,
    input  logic       RESET,
    inout  wire        SDA,
    output logic [7:0] DATA_OUT,
    output logic [6:0] ADRESS_OUT
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        WR_DATA   = 3'd3,
        WR_ACK    = 3'd4,
        RD_DATA   = 3'd5,
        RD_ACK    = 3'd6,
        WAIT_STOP = 3'd7
    } state_t;

`ifdef I2C_SLAVE_ADDR_MATCH_EN
    localparam logic ACCEPT_ALL = 1'b0;
`else
    localparam logic ACCEPT_ALL = 1'b1;
`endif

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        rw_q, rw_d;
    logic [7:0]  data_q, data_d;
    logic [6:0]  addr_q, addr_d;
    logic        sda_hi_q;

    logic        sda_in;
    logic        start_det;
    logic        stop_det;
    logic [7:0]  byte_in;
    logic        addr_hit;
    logic        dir_en;
    logic        drive_bit;

    assign sda_in = SDA;

    // Level seen while SCL was high; compared against SDA at the falling edge.
    always_ff @(posedge SCL or negedge RESET) begin
        if (!RESET) begin
            sda_hi_q <= 1'b1;
        end else begin
            sda_hi_q <= sda_in;
        end
    end

    assign start_det = sda_hi_q & ~sda_in;
    assign stop_det  = ~sda_hi_q & sda_in;
    assign byte_in   = {shift_q[6:0], sda_hi_q};
    assign addr_hit  = ACCEPT_ALL || (byte_in[7:1] == SLAVE_ADDR);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        rw_d      = rw_q;
        data_d    = data_q;
        addr_d    = addr_q;

        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = 3'd0;
        end else if (stop_det) begin
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
        end else begin
            case (state_q)
                ADDR: begin
                    shift_d   = byte_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (addr_hit) begin
                            state_d = ADDR_ACK;
                            addr_d  = byte_in[7:1];
                            rw_d    = byte_in[0];
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: begin
                    bit_cnt_d = 3'd0;
                    if (rw_q) begin
                        state_d = RD_DATA;
                        shift_d = data_q;
                    end else begin
                        state_d = WR_DATA;
                    end
                end
                WR_DATA: begin
                    shift_d   = byte_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        data_d  = byte_in;
                        state_d = WR_ACK;
                    end
                end
                WR_ACK: begin
                    bit_cnt_d = 3'd0;
                    state_d   = WR_DATA;
                end
                RD_DATA: begin
                    // shift_q[7] is the bit on the wire; advance it at each falling edge.
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = RD_ACK;
                    end else begin
                        shift_d = {shift_q[6:0], 1'b0};
                    end
                end
                RD_ACK: begin
                    bit_cnt_d = 3'd0;
                    if (!sda_hi_q) begin
                        state_d = RD_DATA;
                        shift_d = data_q;
                    end else begin
                        state_d = WAIT_STOP;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(negedge SCL or negedge RESET) begin
        if (!RESET) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            rw_q      <= 1'b0;
            data_q    <= 8'h00;
            addr_q    <= 7'h00;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            rw_q      <= rw_d;
            data_q    <= data_d;
            addr_q    <= addr_d;
        end
    end

    // Derived from the state register so reset releases SDA without any SCL edge.
    assign dir_en    = (state_q == ADDR_ACK) || (state_q == WR_ACK) || (state_q == RD_DATA);
    assign drive_bit = (state_q == RD_DATA) ? shift_q[7] : 1'b0;
    assign SDA       = (dir_en && !drive_bit) ? 1'b0 : 1'bz;

    assign DATA_OUT   = data_q;
    assign ADRESS_OUT = addr_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bit-banged I2C master bench for i2c_slave with a scoreboard of expected slot levels and outputs.
module tb_i2c_slave;

    logic       scl = 1'b0;
    logic       rst_n = 1'b0;
    logic       m_low = 1'b0;
    wire        sda;
    logic [7:0] data_out;
    logic [6:0] addr_out;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    int checks = 0;
    int fails  = 0;

    logic [7:0]  model_data;
    logic [6:0]  model_addr;
    logic [1:0]  slot_q[$];   // {dir_en, sda} expected during a bit slot
    logic [14:0] out_q[$];    // {ADRESS_OUT, DATA_OUT} expected after a byte

    i2c_slave dut (
        .SCL        (scl),
        .RESET      (rst_n),
        .SDA        (sda),
        .DATA_OUT   (data_out),
        .ADRESS_OUT (addr_out)
    );

    function automatic logic addr_accepted(input logic [6:0] a);
`ifdef I2C_SLAVE_ADDR_MATCH_EN
        return (a == 7'h28);
`else
        return 1'b1;
`endif
    endfunction

    // One SCL pulse; master drives b (1 = release) and never pulls low while the slave owns SDA.
    task automatic bus_bit(input logic b, output logic [1:0] obs);
        #5 m_low = !b && !dut.dir_en;
        #5 scl = 1'b1;
        #5 obs = {dut.dir_en, sda};
        #5 scl = 1'b0;
    endtask

    task automatic do_start();
        #5 m_low = 1'b0;
        #5 scl = 1'b1;
        #5 m_low = 1'b1;
        #5 scl = 1'b0;
    endtask

    task automatic do_stop();
        #5 m_low = 1'b1;
        #5 scl = 1'b1;
        #5 m_low = 1'b0;
        #5 scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        logic [1:0] o;
        for (int i = 7; i >= 0; i--) bus_bit(v[i], o);
    endtask

    task automatic test_reset();
        logic [1:0] o;
        rst_n = 1'b0;
        m_low = 1'b0;
        bus_bit(1'b1, o);
        bus_bit(1'b1, o);
        rst_n = 1'b1;
        model_data = 8'h00;
        model_addr = 7'h00;
        #5;
        checks++;
        if (data_out !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", data_out); end
        checks++;
        if (addr_out !== 7'h00) begin fails++; $display("FAIL reset_addr: got %h want 00", addr_out); end
        checks++;
        if (dut.dir_en !== 1'b0) begin fails++; $display("FAIL reset_dir_en: got %b want 0", dut.dir_en); end
        checks++;
        if (sda !== 1'b1) begin fails++; $display("FAIL reset_sda_released: got %b want 1", sda); end
        $display("reset: data=%h addr=%h dir_en=%b sda=%b", data_out, addr_out, dut.dir_en, sda);
    endtask

    task automatic test_write();
        logic [1:0]  o, e;
        logic [14:0] eo;
        logic [7:0]  bytes [2];
        bytes[0] = 8'h50;
        bytes[1] = 8'hCC;
        do_start();
        for (int k = 0; k < 2; k++) begin
            send_byte(bytes[k]);
            if (k == 0) model_addr = bytes[k][7:1]; else model_data = bytes[k];
            out_q.push_back({model_addr, model_data});
            slot_q.push_back(2'b10);
            #1;
            eo = out_q.pop_front();
            checks++;
            if ({addr_out, data_out} !== eo) begin
                fails++;
                $display("FAIL write_outputs_byte%0d: got addr=%h data=%h want addr=%h data=%h",
                         k, addr_out, data_out, eo[14:8], eo[7:0]);
            end
            bus_bit(1'b1, o);
            e = slot_q.pop_front();
            checks++;
            if (o !== e) begin fails++; $display("FAIL write_ack_byte%0d: got dir/sda=%b want %b", k, o, e); end
            $display("write byte %h: addr=%h data=%h ack dir/sda=%b", bytes[k], addr_out, data_out, o);
        end
        do_stop();
        #1;
        checks++;
        if (dut.dir_en !== 1'b0) begin fails++; $display("FAIL write_stop_dir_en: got %b want 0", dut.dir_en); end
    endtask

    task automatic test_read_after_write();
        logic [1:0] o, e;
        logic       mbit;
        do_start();
        send_byte(8'h50);
        bus_bit(1'b1, o);
        do_start();
        send_byte(8'h51);
        model_addr = 7'h28;
        slot_q.push_back(2'b10);
        bus_bit(1'b1, o);
        e = slot_q.pop_front();
        checks++;
        if (o !== e) begin fails++; $display("FAIL read_addr_ack: got dir/sda=%b want %b", o, e); end
        // First byte is ACKed by the master (slave resends), second is NACKed.
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 7; i >= 0; i--) slot_q.push_back({1'b1, model_data[i]});
            for (int i = 7; i >= 0; i--) begin
                bus_bit(1'b1, o);
                e = slot_q.pop_front();
                checks++;
                if (o !== e) begin
                    fails++;
                    $display("FAIL read_bit rep%0d bit%0d: got dir/sda=%b want %b", rep, i, o, e);
                end
            end
            mbit = (rep == 0) ? 1'b0 : 1'b1;
            slot_q.push_back({1'b0, mbit});
            bus_bit(mbit, o);
            e = slot_q.pop_front();
            checks++;
            if (o !== e) begin fails++; $display("FAIL read_master_ack rep%0d: got dir/sda=%b want %b", rep, o, e); end
            $display("read byte rep%0d: expected %h, master bit %b", rep, model_data, mbit);
        end
        #1;
        checks++;
        if ({dut.dir_en, sda} !== 2'b01) begin
            fails++;
            $display("FAIL read_nack_release: got dir/sda=%b want 01", {dut.dir_en, sda});
        end
        checks++;
        if ({addr_out, data_out} !== {model_addr, model_data}) begin
            fails++;
            $display("FAIL read_outputs: got addr=%h data=%h want addr=%h data=%h",
                     addr_out, data_out, model_addr, model_data);
        end
        do_stop();
    endtask

    task automatic test_addr_mismatch();
        logic [1:0]  o, e;
        logic [14:0] eo;
        logic        acc;
        acc = addr_accepted(7'h2D);
        do_start();
        send_byte(8'h5A);
        if (acc) model_addr = 7'h2D;
        out_q.push_back({model_addr, model_data});
        slot_q.push_back(acc ? 2'b10 : 2'b01);
        #1;
        eo = out_q.pop_front();
        checks++;
        if (addr_out !== eo[14:8]) begin fails++; $display("FAIL mismatch_addr_out: got %h want %h", addr_out, eo[14:8]); end
        bus_bit(1'b1, o);
        e = slot_q.pop_front();
        checks++;
        if (o !== e) begin fails++; $display("FAIL mismatch_addr_ack: got dir/sda=%b want %b", o, e); end
        send_byte(8'h3C);
        if (acc) model_data = 8'h3C;
        out_q.push_back({model_addr, model_data});
        slot_q.push_back(acc ? 2'b10 : 2'b01);
        #1;
        eo = out_q.pop_front();
        checks++;
        if (data_out !== eo[7:0]) begin fails++; $display("FAIL mismatch_data_out: got %h want %h", data_out, eo[7:0]); end
        bus_bit(1'b1, o);
        e = slot_q.pop_front();
        checks++;
        if (o !== e) begin fails++; $display("FAIL mismatch_data_ack: got dir/sda=%b want %b", o, e); end
        do_stop();
        $display("addr 2D (accepted=%b): addr=%h data=%h", acc, addr_out, data_out);
    endtask

    task automatic test_aborted_byte();
        logic [1:0] o, e;
        logic [2:0] st;
        do_start();
        send_byte(8'h50);
        bus_bit(1'b1, o);
        for (int i = 7; i >= 4; i--) bus_bit(8'hA5 >> i, o);
        do_stop();
        #1;
        st = dut.state_q;
        checks++;
        if (st !== 3'd0) begin fails++; $display("FAIL abort_state_idle: got %0d want 0", st); end
        checks++;
        if (data_out !== model_data) begin fails++; $display("FAIL abort_data_kept: got %h want %h", data_out, model_data); end
        do_start();
        send_byte(8'h50);
        slot_q.push_back(2'b10);
        bus_bit(1'b1, o);
        e = slot_q.pop_front();
        checks++;
        if (o !== e) begin fails++; $display("FAIL abort_restart_ack: got dir/sda=%b want %b", o, e); end
        do_stop();
        $display("aborted byte: data=%h kept, restart ack dir/sda=%b", data_out, o);
    endtask

    task automatic test_reset_during_read();
        logic [1:0] o, e;
        do_start();
        send_byte(8'h50);
        bus_bit(1'b1, o);
        send_byte(8'hA5);
        model_data = 8'hA5;
        bus_bit(1'b1, o);
        do_start();
        send_byte(8'h51);
        bus_bit(1'b1, o);
        for (int i = 7; i >= 4; i--) slot_q.push_back({1'b1, model_data[i]});
        for (int i = 7; i >= 4; i--) begin
            bus_bit(1'b1, o);
            e = slot_q.pop_front();
            checks++;
            if (o !== e) begin fails++; $display("FAIL rstread_bit%0d: got dir/sda=%b want %b", i, o, e); end
        end
        #1;
        checks++;
        if ({dut.dir_en, sda} !== {1'b1, model_data[3]}) begin
            fails++;
            $display("FAIL rstread_bit3_driven: got dir/sda=%b want %b", {dut.dir_en, sda}, {1'b1, model_data[3]});
        end
        rst_n = 1'b0;
        model_data = 8'h00;
        model_addr = 7'h00;
        #1;
        checks++;
        if ({dut.dir_en, sda} !== 2'b01) begin
            fails++;
            $display("FAIL rstread_release: got dir/sda=%b want 01", {dut.dir_en, sda});
        end
        checks++;
        if ({addr_out, data_out} !== {model_addr, model_data}) begin
            fails++;
            $display("FAIL rstread_outputs: got addr=%h data=%h want 00/00", addr_out, data_out);
        end
        bus_bit(1'b1, o);
        rst_n = 1'b1;
        $display("reset during read: dir_en=%b sda=%b", dut.dir_en, sda);
    endtask

    task automatic test_back_to_back();
        logic [1:0] o, e;
        logic [7:0] vals [3];
        vals[0] = 8'h77;
        vals[1] = 8'h12;
        vals[2] = 8'hF0;
        do_start();
        send_byte(8'h50);
        model_addr = 7'h28;
        bus_bit(1'b1, o);
        for (int k = 0; k < 3; k++) begin
            send_byte(vals[k]);
            model_data = vals[k];
            out_q.push_back({model_addr, model_data});
            slot_q.push_back(2'b10);
            #1;
            checks++;
            if ({addr_out, data_out} !== out_q[0]) begin
                fails++;
                $display("FAIL b2b_outputs%0d: got addr=%h data=%h want addr=%h data=%h",
                         k, addr_out, data_out, out_q[0][14:8], out_q[0][7:0]);
            end
            void'(out_q.pop_front());
            bus_bit(1'b1, o);
            e = slot_q.pop_front();
            checks++;
            if (o !== e) begin fails++; $display("FAIL b2b_ack%0d: got dir/sda=%b want %b", k, o, e); end
            $display("back-to-back byte %h: data=%h ack dir/sda=%b", vals[k], data_out, o);
        end
        do_stop();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_after_write();
        test_addr_mismatch();
        test_aborted_byte();
        test_reset_during_read();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
# i2c_slave

Single-address I2C slave clocked entirely by the bus SCL. It detects START and STOP conditions and accepts master write transactions, presenting the captured 7-bit address and the last written data byte on parallel outputs. For master reads, it shifts the stored byte back out over SDA. It sits at the pin boundary between an external I2C master and on-chip logic.

## Interface
- SLAVE_ADDR, 7'h28, 7-bit address this slave responds to.
- SCL  input  1  bus clock; the only clock of the block.
- RESET  input  1  asynchronous, active-low reset.
- SDA  inout  1  bus data line.
  - Driven open-drain: the block drives 0 or releases to Z.
  - Internal signal `dir_en` is 1 whenever the slave owns SDA. The bench reads it hierarchically and releases its own driver while it is 1.
- DATA_OUT  output  8  last data byte received in a write transfer.
- ADRESS_OUT  output  7  address field of the last accepted address byte.

## Operation
- **Bit sampling**
  - On SCL rising edge, SDA is sampled into `sda_hi`.
  - On SCL falling edge, the current SDA level is compared with `sda_hi`.
- **START and STOP detection** (at each SCL falling edge)
  - `sda_hi`=1 and SDA=0 → START.
  - `sda_hi`=0 and SDA=1 → STOP.
  - Otherwise `sda_hi` is the received bit.
- **Priority:** START and STOP take priority over any state.
  - START in any state → ADDR, bit counter cleared. This is how repeated START is supported.
  - STOP in any state → IDLE.
- **Bit order:** bytes are shifted MSB-first. Address byte = {addr[6:0], rw}.
- **FSM states**
  - IDLE: wait for START.
  - ADDR: shift 8 bits. After the 8th bit:
    - On match → ADDR_ACK and load ADRESS_OUT.
    - On mismatch → WAIT_STOP.
  - ADDR_ACK: drive SDA=0 for one bit.
    - Then rw=0 → WR_DATA.
    - rw=1 → RD_DATA, with the stored byte loaded into the shift register.
  - WR_DATA: shift 8 bits; on the 8th bit, DATA_OUT ← byte → WR_ACK.
  - WR_ACK: drive SDA=0 for one bit → WR_DATA (multi-byte writes overwrite DATA_OUT).
  - RD_DATA: drive the 8 bits MSB-first → RD_ACK.
  - RD_ACK: release SDA and sample the master bit.
    - 0 (ACK) → RD_DATA, resending the same byte.
    - 1 (NACK) → WAIT_STOP.
  - WAIT_STOP: SDA released, all inputs ignored until STOP or START.
- **Read data source:** the byte returned on reads is the DATA_OUT register (loopback of the last write); it is 8'h00 after reset.
- **`dir_en`:**
  - Set to 1 during ADDR_ACK, WR_ACK and RD_DATA.
  - Set to 0 in every other state.
  - While 1, SDA = drive bit (0 or Z).
- **Incomplete bytes:** a partial byte aborted by START or STOP never updates DATA_OUT or ADRESS_OUT.

## Timing
- **Reset:** RESET=0 asynchronously forces:
  - State IDLE and bit counter 0.
  - `dir_en`=0, SDA released.
  - DATA_OUT=8'h00, ADRESS_OUT=7'h00, `sda_hi`=1.
- **Output updates:** ADRESS_OUT and DATA_OUT update on the SCL falling edge that ends the 8th bit of their byte.
- **Slave-driven SDA changes:** these happen only on SCL falling edges.
  - ACK is asserted on the falling edge after the 8th bit.
  - ACK is released on the falling edge after the 9th bit.
- **Read timing:**
  - Read bit 7 is driven on the falling edge ending ADDR_ACK.
  - SDA is released on the falling edge ending bit 0.
- **Master timing requirement:** the master must hold SDA stable from SCL rising edge through the next falling edge for data bits. A change in that window is interpreted as START or STOP.
- **Reset mid-transfer:** aborts immediately; the next transaction must begin with a START.

## Configuration
- Macro: I2C_SLAVE_ADDR_MATCH_EN.
- **Defined:** the address field is compared with SLAVE_ADDR.
  - Mismatch → no ACK, ADRESS_OUT unchanged, WAIT_STOP.
- **Not defined:** every address is accepted and ACKed (promiscuous mode).
  - ADRESS_OUT is loaded for every address byte.

## Test plan
- **Reset:**
  - Stimulus: RESET low for 2 SCL cycles, then high.
  - Required: DATA_OUT=8'h00, ADRESS_OUT=7'h00, `dir_en`=0, SDA=Z.
- **Write:**
  - Stimulus: START, byte 8'h50, ACK slot, byte 8'hCC, ACK slot, STOP.
  - Required: `dir_en`=1 and SDA=0 in both ACK slots; ADRESS_OUT=7'h28; DATA_OUT=8'hCC.
- **Read after write (repeated START):**
  - Stimulus: repeated START, byte 8'h51.
  - Required: ACK; slave drives 1,1,0,0,1,1,0,0; master NACK → SDA released; DATA_OUT unchanged.
- **Address mismatch (macro defined):**
  - Stimulus: START, byte 8'h5A.
  - Required: no ACK, `dir_en` stays 0, ADRESS_OUT unchanged; the following data byte is ignored until STOP.
- **Aborted byte:**
  - Stimulus: STOP after 4 bits of a write data byte.
  - Required: state IDLE, DATA_OUT keeps its previous value; a new START with 8'h50 is ACKed.
- **Reset during read:**
  - Stimulus: assert RESET while the slave is driving read bit 3.
  - Required: `dir_en`=0 and SDA=Z immediately, with no SCL edge needed.
